// File: rtl/ip_lb_dst_steer.sv
// Flow steering stage: holds the leading flits of a message until the 4-tuple hash selects a
// destination tile, rewrites the header's dst x/y to that tile, then forwards the message.
`timescale 1ns/1ps
module ip_lb_dst_steer #(
    parameter int NUM_DSTS_LOG2  = 2,
    parameter int XY_W           = 8,
    parameter int BUF_DEPTH      = 8,
    parameter int NOC_DATA_WIDTH = 64,
    parameter int HDR_DST_X_LSB  = NOC_DATA_WIDTH - XY_W,
    parameter int HDR_DST_Y_LSB  = NOC_DATA_WIDTH - 2 * XY_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      src_steer_val,
    input  logic [NOC_DATA_WIDTH-1:0]                 src_steer_data,
    input  logic                                      src_steer_last,
    output logic                                      steer_src_rdy,
    input  logic                                      src_steer_tuple_val,
    input  logic [95:0]                               src_steer_tuple,
    output logic                                      steer_src_tuple_rdy,
    output logic                                      steer_dst_val,
    output logic [NOC_DATA_WIDTH-1:0]                 steer_dst_data,
    output logic                                      steer_dst_last,
    input  logic                                      dst_steer_rdy,
    input  logic [(2**NUM_DSTS_LOG2)*2*XY_W-1:0]      dst_table,
    output logic [NUM_DSTS_LOG2-1:0]                  steer_dst_idx,
    output logic [1:0]                                steer_state_dbg
);

    // Handshakes: a transfer happens on a rising edge where val and rdy are both high; a sender
    // holds val and its payload steady until that edge, and rdy never waits on val.
    // The tuple is packed {src_ip[95:64], dst_ip[63:32], src_port[31:16], dst_port[15:0]}.

    localparam int TUPLE_W    = 96;
    localparam int NUM_SLICES = (TUPLE_W + NUM_DSTS_LOG2 - 1) / NUM_DSTS_LOG2;
    localparam int HASH_W     = NUM_SLICES * NUM_DSTS_LOG2;
    localparam int AW         = $clog2(BUF_DEPTH);
    localparam int PTR_W      = AW + 1;
    localparam int ENTRY_W    = 2 * XY_W;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_BUFFER = 2'd0,
        ST_HASH   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_PASS   = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [TUPLE_W-1:0]         tuple_q, tuple_d;
    logic [NUM_DSTS_LOG2-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0]         dst_xy_q, dst_xy_d;
    logic                       hdr_pending_q, hdr_pending_d;
    logic                       buf_has_last_q, buf_has_last_d;

    logic [NOC_DATA_WIDTH:0]    buf_mem_q [BUF_DEPTH];
    logic                       buf_push;
    logic                       buf_empty;
    logic                       buf_full;
    logic [NOC_DATA_WIDTH-1:0]  head_data;
    logic                       head_last;
    logic [NOC_DATA_WIDTH-1:0]  hdr_data;
    logic [HASH_W-1:0]          hash_in;
    logic [NUM_DSTS_LOG2-1:0]   hash_idx;
    logic [ENTRY_W-1:0]         table_entry;

    assign buf_empty = (wr_ptr_q == rd_ptr_q);
    assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign steer_dst_idx   = idx_q;
    assign steer_state_dbg = state_q;

    always_comb begin
        hash_in  = HASH_W'(tuple_q);
        hash_idx = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            hash_idx = hash_idx ^ hash_in[i*NUM_DSTS_LOG2 +: NUM_DSTS_LOG2];
        end
        table_entry = dst_table[int'(hash_idx)*ENTRY_W +: ENTRY_W];
    end

    always_comb begin
        {head_last, head_data} = buf_mem_q[rd_ptr_q[AW-1:0]];
        hdr_data = head_data;
        hdr_data[HDR_DST_X_LSB +: XY_W] = dst_xy_q[ENTRY_W-1 -: XY_W];
        hdr_data[HDR_DST_Y_LSB +: XY_W] = dst_xy_q[XY_W-1:0];
    end

    always_comb begin
        state_d             = state_q;
        wr_ptr_d            = wr_ptr_q;
        rd_ptr_d            = rd_ptr_q;
        tuple_d             = tuple_q;
        idx_d               = idx_q;
        dst_xy_d            = dst_xy_q;
        hdr_pending_d       = hdr_pending_q;
        buf_has_last_d      = buf_has_last_q;
        buf_push            = 1'b0;
        steer_src_rdy       = 1'b0;
        steer_src_tuple_rdy = 1'b0;
        steer_dst_val       = 1'b0;
        steer_dst_data      = '0;
        steer_dst_last      = 1'b0;

        case (state_q)
            ST_BUFFER: begin
                // Once a message's last flit is buffered, the next message must wait for its own hash.
                steer_src_rdy       = !buf_full && !buf_has_last_q;
                steer_src_tuple_rdy = !buf_empty;
                buf_push            = src_steer_val && steer_src_rdy;
                if (buf_push) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (src_steer_last) begin
                        buf_has_last_d = 1'b1;
                    end
                end
                if (src_steer_tuple_val && steer_src_tuple_rdy) begin
                    tuple_d = src_steer_tuple;
                    state_d = ST_HASH;
                end
            end
            ST_HASH: begin
                idx_d         = hash_idx;
                dst_xy_d      = table_entry;
                hdr_pending_d = 1'b1;
                state_d       = ST_DRAIN;
            end
            ST_DRAIN: begin
                steer_dst_val  = !buf_empty;
                steer_dst_data = hdr_pending_q ? hdr_data : head_data;
                steer_dst_last = head_last;
                if (steer_dst_val && dst_steer_rdy) begin
                    rd_ptr_d      = rd_ptr_q + PTR_ONE;
                    hdr_pending_d = 1'b0;
                    if ((rd_ptr_q + PTR_ONE) == wr_ptr_q) begin
                        buf_has_last_d = 1'b0;
                        state_d        = head_last ? ST_BUFFER : ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                steer_dst_val  = src_steer_val;
                steer_dst_data = src_steer_data;
                steer_dst_last = src_steer_last;
                steer_src_rdy  = dst_steer_rdy;
                if (src_steer_val && dst_steer_rdy && src_steer_last) begin
                    state_d = ST_BUFFER;
                end
            end
            default: state_d = ST_BUFFER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_BUFFER;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            tuple_q        <= '0;
            idx_q          <= '0;
            dst_xy_q       <= '0;
            hdr_pending_q  <= 1'b0;
            buf_has_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            tuple_q        <= tuple_d;
            idx_q          <= idx_d;
            dst_xy_q       <= dst_xy_d;
            hdr_pending_q  <= hdr_pending_d;
            buf_has_last_q <= buf_has_last_d;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (buf_push) begin
            buf_mem_q[wr_ptr_q[AW-1:0]] <= {src_steer_last, src_steer_data};
        end
    end

endmodule

// File: tb/tb_ip_lb_dst_steer.sv
// Directed bench for ip_lb_dst_steer: drivers issue messages and push expected flits into a
// queue; an independent monitor pops and compares every flit the DUT hands downstream.
`timescale 1ns/1ps
module tb_ip_lb_dst_steer;

    localparam int N     = 2;
    localparam int XY_W  = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int EXP_W = 1 + N + 1 + DW;  // {is_hdr, idx, last, data}
    localparam logic [1:0] S_BUFFER = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_PASS   = 2'd3;

    logic            clk;
    logic            rst_n;
    logic            src_steer_val;
    logic [DW-1:0]   src_steer_data;
    logic            src_steer_last;
    logic            steer_src_rdy;
    logic            src_steer_tuple_val;
    logic [95:0]     src_steer_tuple;
    logic            steer_src_tuple_rdy;
    logic            steer_dst_val;
    logic [DW-1:0]   steer_dst_data;
    logic            steer_dst_last;
    logic            dst_steer_rdy;
    logic [63:0]     dst_table;
    logic [N-1:0]    steer_dst_idx;
    logic [1:0]      steer_state_dbg;

    // Entry i = {x = 0x10+i, y = 0x20+i}
    assign dst_table = {16'h1323, 16'h1222, 16'h1121, 16'h1020};

    ip_lb_dst_steer #(
        .NUM_DSTS_LOG2  (N),
        .XY_W           (XY_W),
        .BUF_DEPTH      (DEPTH),
        .NOC_DATA_WIDTH (DW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .src_steer_val       (src_steer_val),
        .src_steer_data      (src_steer_data),
        .src_steer_last      (src_steer_last),
        .steer_src_rdy       (steer_src_rdy),
        .src_steer_tuple_val (src_steer_tuple_val),
        .src_steer_tuple     (src_steer_tuple),
        .steer_src_tuple_rdy (steer_src_tuple_rdy),
        .steer_dst_val       (steer_dst_val),
        .steer_dst_data      (steer_dst_data),
        .steer_dst_last      (steer_dst_last),
        .dst_steer_rdy       (dst_steer_rdy),
        .dst_table           (dst_table),
        .steer_dst_idx       (steer_dst_idx),
        .steer_state_dbg     (steer_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] msg_data [0:15];
    int  msg_len;
    int  flits_acc;
    bit  tuple_done;
    int  t_hs;
    bit  rand_rdy = 1'b0;
    bit  hold_rdy = 1'b1;
    int  mon_cnt;
    int  mon_first;
    int  mon_last;
    bit  saw_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Bit k of the index is the parity of all tuple bits whose position is k mod N.
    function automatic logic [N-1:0] model_idx(input logic [95:0] t);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < 96; i++) r[i % N] = r[i % N] ^ t[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] model_hdr(input logic [DW-1:0] d, input logic [N-1:0] idx);
        logic [DW-1:0] r;
        r = d;
        r[63:56] = 8'h10 + {6'd0, idx};
        r[55:48] = 8'h20 + {6'd0, idx};
        return r;
    endfunction

    task automatic push_expected(input logic [N-1:0] idx);
        for (int i = 0; i < msg_len; i++) begin
            exp_q.push_back({(i == 0), idx, (i == msg_len - 1),
                             (i == 0) ? model_hdr(msg_data[i], idx) : msg_data[i]});
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        dst_steer_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_steer_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
        end
    end

    task automatic wait_tuple_done();
        int b;
        b = 0;
        while (!tuple_done && b < 500) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (!tuple_done) timeout_fail("flit_wait_tuple");
    endtask

    task automatic drive_flits(input int n_hold);
        bit hs;
        int b;
        for (int i = 0; i < msg_len; i++) begin
            if (i >= n_hold) wait_tuple_done();
            src_steer_val  = 1'b1;
            src_steer_data = msg_data[i];
            src_steer_last = (i == msg_len - 1);
            hs = 1'b0;
            b  = 0;
            while (!hs && b < 500) begin
                @(negedge clk);
                hs = steer_src_rdy;
                @(posedge clk);
                #1;
                b++;
            end
            src_steer_val = 1'b0;
            if (!hs) begin
                timeout_fail("flit_accept");
                return;
            end
            flits_acc++;
        end
    endtask

    task automatic drive_tuple(input logic [95:0] t, input int wait_flits, input int delay,
                               input bit early, input bit chk_full);
        bit hs;
        int b;
        int acc_at_hs;
        b = 0;
        acc_at_hs = 0;
        if (!early) begin
            while (flits_acc < wait_flits && b < 500) begin
                @(posedge clk);
                #1;
                b++;
            end
            repeat (delay) begin
                @(posedge clk);
                #1;
            end
        end
        if (chk_full) begin
            @(negedge clk);
            chk("buf_full_rdy", {63'd0, steer_src_rdy}, 64'd0);
            chk("buf_full_accepted", 64'(flits_acc), 64'(DEPTH));
            @(posedge clk);
            #1;
        end
        src_steer_tuple     = t;
        src_steer_tuple_val = 1'b1;
        hs = 1'b0;
        b  = 0;
        while (!hs && b < 500) begin
            @(negedge clk);
            hs        = steer_src_tuple_rdy;
            acc_at_hs = flits_acc;
            t_hs      = cyc;
            @(posedge clk);
            #1;
            b++;
        end
        src_steer_tuple_val = 1'b0;
        if (!hs) begin
            timeout_fail("tuple_accept");
        end else begin
            checks++;
            if (acc_at_hs < 1) begin
                errors++;
                $display("FAIL early_tuple: accepted with %0d flits buffered, required at least 1", acc_at_hs);
            end
        end
        tuple_done = 1'b1;
    endtask

    task automatic run_msg(input logic [95:0] t, input int n_hold, input int wait_flits,
                           input int delay, input bit early, input bit chk_full);
        flits_acc  = 0;
        tuple_done = 1'b0;
        fork
            drive_flits(n_hold);
            drive_tuple(t, wait_flits, delay, early, chk_full);
        join
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 1000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (steer_state_dbg == S_PASS) saw_pass = 1'b1;
                if (prev_stall) begin
                    chk("stall_val", {63'd0, steer_dst_val}, 64'd1);
                    chk("stall_data", steer_dst_data, prev_data);
                end
                prev_stall = steer_dst_val && !dst_steer_rdy;
                prev_data  = steer_dst_data;
                if (steer_dst_val && dst_steer_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: data %h with nothing expected", steer_dst_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", steer_dst_data, e[DW-1:0]);
                        chk("out_last", {63'd0, steer_dst_last}, {63'd0, e[DW]});
                        if (e[EXP_W-1]) chk("out_idx", 64'(steer_dst_idx), 64'(e[DW+N:DW+1]));
                        if (mon_cnt == 0) mon_first = cyc;
                        mon_last = cyc;
                        mon_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [95:0] t;
        logic [N-1:0] idx;
        int len;
        int wf;

        rst_n               = 1'b0;
        src_steer_val       = 1'b0;
        src_steer_data      = '0;
        src_steer_last      = 1'b0;
        src_steer_tuple_val = 1'b0;
        src_steer_tuple     = '0;
        saw_pass            = 1'b0;
        mon_cnt             = 0;
        mon_first           = 0;
        mon_last            = 0;
        t_hs                = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_src_rdy", {63'd0, steer_src_rdy}, 64'd1);
        chk("rst_tuple_rdy", {63'd0, steer_src_tuple_rdy}, 64'd0);
        chk("rst_dst_val", {63'd0, steer_dst_val}, 64'd0);
        chk("rst_dst_last", {63'd0, steer_dst_last}, 64'd0);
        chk("rst_idx", 64'(steer_dst_idx), 64'd0);
        chk("rst_tuple_rdy_early", {63'd0, steer_src_tuple_rdy}, 64'd0);
        @(posedge clk);
        #1;

        // Hash check with hand-computed result: idx 2 -> {x,y} = {0x12,0x22}
        msg_len = 3;
        msg_data[0] = 64'h5A5A_0011_2233_4455;
        msg_data[1] = 64'h1111_2222_3333_4444;
        msg_data[2] = 64'h5555_6666_7777_8888;
        exp_q.push_back({1'b1, 2'd2, 1'b0, 64'h1222_0011_2233_4455});
        exp_q.push_back({1'b0, 2'd2, 1'b0, 64'h1111_2222_3333_4444});
        exp_q.push_back({1'b0, 2'd2, 1'b1, 64'h5555_6666_7777_8888});
        run_msg({32'h0A00_0001, 32'h0A00_0002, 16'h1234, 16'h0050}, 3, 1, 0, 1'b0, 1'b0);
        wait_drain();

        // Ordering and latency: 8 flits, 3 buffered, tuple one cycle after the 3rd
        msg_len = 8;
        for (int i = 0; i < 8; i++) msg_data[i] = {$urandom, $urandom};
        t = {32'hC0A8_0101, 32'h0A0A_0A0A, 16'h8080, 16'h01BB};
        push_expected(model_idx(t));
        mon_cnt = 0;
        run_msg(t, 3, 3, 1, 1'b0, 1'b0);
        wait_drain();
        chk("order_count", 64'(mon_cnt), 64'd8);
        chk("order_first_latency", 64'(mon_first - t_hs), 64'd2);
        chk("order_rate", 64'(mon_last - mon_first), 64'd7);

        // Buffer full: tuple withheld long enough for the buffer to fill
        msg_len = 6;
        for (int i = 0; i < 6; i++) msg_data[i] = {$urandom, $urandom};
        t = {32'hDEAD_BEEF, 32'h0102_0304, 16'hFFFF, 16'h0001};
        push_expected(model_idx(t));
        run_msg(t, 6, 1, 20, 1'b0, 1'b1);
        wait_drain();

        // Short message fully buffered before the tuple: no PASS cycle
        saw_pass = 1'b0;
        msg_len = 3;
        for (int i = 0; i < 3; i++) msg_data[i] = {$urandom, $urandom};
        t = {32'h1234_5678, 32'h9ABC_DEF0, 16'h0F0F, 16'hF0F0};
        push_expected(model_idx(t));
        run_msg(t, 3, 3, 2, 1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        chk("short_state_buffer", 64'(steer_state_dbg), 64'(S_BUFFER));
        @(posedge clk);
        #1;
        chk("short_no_pass", {63'd0, saw_pass}, 64'd0);

        // Reset in the middle of DRAIN
        hold_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        msg_len = 3;
        for (int i = 0; i < 3; i++) msg_data[i] = {$urandom, $urandom};
        t = {32'h0000_0003, 32'h0000_0000, 16'h0000, 16'h0000};
        push_expected(model_idx(t));
        run_msg(t, 3, 3, 0, 1'b0, 1'b0);
        begin
            int b;
            b = 0;
            while (steer_state_dbg != S_DRAIN && b < 50) begin
                @(negedge clk);
                b++;
            end
            if (steer_state_dbg != S_DRAIN) timeout_fail("reach_drain");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_src_rdy", {63'd0, steer_src_rdy}, 64'd1);
        chk("mid_rst_tuple_rdy", {63'd0, steer_src_tuple_rdy}, 64'd0);
        chk("mid_rst_dst_val", {63'd0, steer_dst_val}, 64'd0);
        chk("mid_rst_dst_last", {63'd0, steer_dst_last}, 64'd0);
        chk("mid_rst_idx", 64'(steer_dst_idx), 64'd0);
        @(posedge clk);
        #1;
        hold_rdy = 1'b1;

        // Message after reset, hand-computed: idx 2
        msg_len = 2;
        msg_data[0] = 64'hFFFF_AAAA_BBBB_CCCC;
        msg_data[1] = 64'h0123_4567_89AB_CDEF;
        exp_q.push_back({1'b1, 2'd2, 1'b0, 64'h1222_AAAA_BBBB_CCCC});
        exp_q.push_back({1'b0, 2'd2, 1'b1, 64'h0123_4567_89AB_CDEF});
        run_msg({32'h0A00_0001, 32'h0A00_0002, 16'h1234, 16'h0050}, 2, 1, 0, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back messages under random downstream backpressure
        rand_rdy = 1'b1;
        for (int m = 0; m < 50; m++) begin
            len = $urandom_range(1, 9);
            wf  = $urandom_range(1, (len < DEPTH) ? len : DEPTH);
            msg_len = len;
            for (int i = 0; i < len; i++) msg_data[i] = {$urandom, $urandom};
            t = {$urandom, $urandom, 16'($urandom), 16'($urandom)};
            idx = model_idx(t);
            push_expected(idx);
            run_msg(t, DEPTH, wf, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end
        wait_drain();
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
